pll_dri_master: RTL and testbench
=================================

PLL_DRI_MASTER -- requirements
Module: pll_dri_master

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, the maximum number of cycles spent in WAIT_ACK before an error response.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535, the maximum number of cycles spent in WAIT_LOCK before an error response.
REQ-003 SHALL have parameter LOCK_STABLE, default 16, the number of consecutive PLL_LOCK-high cycles required before a relock completes.
REQ-004 SHALL have port CLK, input, 1, the single clock for all logic.
REQ-005 SHALL have port RESETN, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1, host request strobe.
REQ-007 SHALL have port req_ready, output, 1, block can accept a request.
REQ-008 SHALL have port req_write, input, 1, 1=write, 0=read.
REQ-009 SHALL have port req_relock, input, 1, on a write, wait for PLL relock before responding.
REQ-010 SHALL have port req_addr, input, 9, PLL DRI register address.
REQ-011 SHALL have port req_wdata, input, 32, write data.
REQ-012 SHALL have port resp_valid, output, 1, response available.
REQ-013 SHALL have port resp_ready, input, 1, host accepts the response.
REQ-014 SHALL have port resp_rdata, output, 32, read data; 0 for writes and errors.
REQ-015 SHALL have port resp_err, output, 1, timeout occurred.
REQ-016 SHALL have port DRI_CTRL, output, 11, to the PLL: [10]=strobe, [9]=write, [8:0]=addr.
REQ-017 SHALL have port DRI_WDATA, output, 33, to the PLL: [32]=0, [31:0]=data.
REQ-018 SHALL have port DRI_RDATA, input, 33, from the PLL: [32]=ack, [31:0]=read data.
REQ-019 SHALL have port DRI_ARST_N, output, 1, PLL DRI reset, equal to RESETN.
REQ-020 SHALL have port DRI_INTERRUPT, input, 1, PLL interrupt.
REQ-021 SHALL have port PLL_LOCK, input, 1, PLL lock indicator.
REQ-022 SHALL have port irq_pending, output, 1, sticky latch of DRI_INTERRUPT.
REQ-023 SHALL have port irq_clear, input, 1, clears irq_pending.

Function
REQ-024 SHALL implement the state machine IDLE, ISSUE, WAIT_ACK, WAIT_LOCK and RESP; req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on req_valid&req_ready.
REQ-025 On acceptance, SHALL register write, relock, addr and wdata, and move to ISSUE.
REQ-026 In ISSUE, SHALL drive DRI_CTRL={1,write,addr} and DRI_WDATA={0,wdata} for exactly one cycle, then go to WAIT_ACK.
REQ-027 DRI_CTRL[10] SHALL be 0 in every other state; DRI_CTRL[9:0] and DRI_WDATA SHALL hold their last values.
REQ-028 In WAIT_ACK, SHALL increment the timeout counter each cycle; on DRI_RDATA[32]=1, SHALL capture DRI_RDATA[31:0] into resp_rdata for reads (0 for writes).
REQ-029 After the ack in REQ-028, SHALL go to WAIT_LOCK if write&relock, else to RESP.
REQ-030 In WAIT_ACK, if the counter reaches ACK_TIMEOUT with no ack, SHALL set resp_err=1, set resp_rdata=0, and go to RESP.
REQ-031 An ack in the same cycle the counter reaches ACK_TIMEOUT SHALL be treated as success.
REQ-032 In WAIT_LOCK, SHALL count consecutive PLL_LOCK=1 cycles, reset that count to 0 on any PLL_LOCK=0, and go to RESP with resp_err=0 when the count reaches LOCK_STABLE.
REQ-033 In WAIT_LOCK, after LOCK_TIMEOUT total cycles without success, SHALL set resp_err=1 and go to RESP.
REQ-034 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be stable until resp_valid&resp_ready, then the block SHALL go to IDLE; req_ready SHALL be 1 the following cycle.
REQ-035 Best-case read latency SHALL be 4 cycles: acceptance -> ISSUE -> WAIT_ACK with ack in the first cycle -> resp_valid.
REQ-036 A DRI_RDATA[32] pulse outside WAIT_ACK SHALL be ignored.
REQ-037 The timeout, stable and lock counters SHALL be cleared on entering WAIT_ACK and WAIT_LOCK, and SHALL be sized ceil(log2(param+1)) bits with no wrap.
REQ-038 irq_pending SHALL be set when DRI_INTERRUPT=1 and cleared on irq_clear=1; if both occur in the same cycle, set SHALL win.

Reset
REQ-039 While RESETN=0, SHALL force state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, DRI_CTRL=0, DRI_WDATA=0, irq_pending=0 and all counters=0.
REQ-040 SHALL set req_ready=1 on the first CLK edge after RESETN deasserts.
REQ-041 Reset asserted mid-transaction SHALL abort it with no response; a later ack SHALL be ignored.

Verification
REQ-042 Read addr=0x005, PLL acks after 3 cycles with data 0xA5A5_0001 -> exactly one DRI_CTRL[10] pulse with DRI_CTRL=0x405, then resp_valid with rdata=0xA5A50001 and err=0.
REQ-043 Write addr=0x010, data=0x12345678, relock=1; PLL_LOCK is low for 20 cycles, high 5 cycles, low 3, then high -> response only after 16 consecutive high cycles, err=0, rdata=0.
REQ-044 Read with no ack, ACK_TIMEOUT=255 -> resp_valid with err=1 and rdata=0, 255 cycles after entering WAIT_ACK; a late ack is ignored and the next request succeeds.
REQ-045 resp_ready held low 10 cycles -> resp_valid and data stable, req_ready=0 throughout; a req_valid asserted during this time is not accepted.
REQ-046 DRI_INTERRUPT and irq_clear both high in one cycle -> irq_pending=1; irq_clear alone next cycle -> irq_pending=0.
REQ-047 RESETN asserted during WAIT_LOCK -> all outputs at reset values immediately; after release, req_ready=1 after one edge and resp_valid never rises for the aborted request.

Source files
------------

// File: rtl/pll_dri_master.sv
// Host-to-PLL DRI bridge: takes one read/write request at a time, issues a
// single DRI strobe, waits for the PLL ack (and optionally for a stable
// relock), then holds the response until the host takes it.
//
// Handshakes: a request transfers on the rising edge where req_valid and
// req_ready are both 1; a response transfers on the rising edge where
// resp_valid and resp_ready are both 1. The source keeps its payload stable
// while valid is high and not yet accepted; ready never depends on valid.
module pll_dri_master #(
    parameter int ACK_TIMEOUT  = 255,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 16
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_relock,
    input  logic [8:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [10:0] DRI_CTRL,
    output logic [32:0] DRI_WDATA,
    input  logic [32:0] DRI_RDATA,
    output logic        DRI_ARST_N,
    input  logic        DRI_INTERRUPT,
    input  logic        PLL_LOCK,
    output logic        irq_pending,
    input  logic        irq_clear,
    output logic [2:0]  dbg_state
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int LCK_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);

    // "LAST" is the counter value in the final permitted cycle of a wait;
    // "MAX" is the saturation value so the counters never wrap.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(ACK_TIMEOUT);
    localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [LCK_W-1:0] LCK_MAX  = LCK_W'(LOCK_TIMEOUT);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(LOCK_STABLE);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             ready_en;
    logic             wr_q;
    logic             relock_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic [LCK_W-1:0] lock_cnt;
    logic [STB_W-1:0] stb_cnt;

    logic ack;
    logic ack_expire;
    logic lock_done;
    logic lock_expire;

    // An ack in the last permitted cycle wins over the timeout because the
    // next-state logic tests ack first.
    assign ack         = DRI_RDATA[32];
    assign ack_expire  = (tmo_cnt == TMO_LAST);
    assign lock_done   = PLL_LOCK && (stb_cnt == STB_LAST);
    assign lock_expire = (lock_cnt == LCK_LAST);

    assign DRI_ARST_N = RESETN;
    assign dbg_state  = state;

    // State register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = ready_en;
                accept    = req_valid && ready_en;
                if (accept) state_next = ST_ISSUE;
            end
            ST_ISSUE: state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (ack)             state_next = (wr_q && relock_q) ? ST_WAIT_LOCK : ST_RESP;
                else if (ack_expire) state_next = ST_RESP;
            end
            ST_WAIT_LOCK: begin
                if (lock_done || lock_expire) state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, DRI drive, wait counters and response payload.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ready_en   <= 1'b0;
            wr_q       <= 1'b0;
            relock_q   <= 1'b0;
            DRI_CTRL   <= '0;
            DRI_WDATA  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            tmo_cnt    <= '0;
            lock_cnt   <= '0;
            stb_cnt    <= '0;
        end else begin
            // Keeps req_ready low until the first edge after reset release.
            ready_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wr_q       <= req_write;
                        relock_q   <= req_relock;
                        DRI_CTRL   <= {1'b1, req_write, req_addr};
                        DRI_WDATA  <= {1'b0, req_wdata};
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    // Strobe lasts exactly the ISSUE cycle; addr/data are held.
                    DRI_CTRL[10] <= 1'b0;
                    tmo_cnt      <= '0;
                    lock_cnt     <= '0;
                    stb_cnt      <= '0;
                end
                ST_WAIT_ACK: begin
                    if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
                    if (ack) begin
                        resp_rdata <= wr_q ? '0 : DRI_RDATA[31:0];
                        lock_cnt   <= '0;
                        stb_cnt    <= '0;
                    end else if (ack_expire) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_cnt != LCK_MAX) lock_cnt <= lock_cnt + 1'b1;
                    if (!PLL_LOCK)                stb_cnt <= '0;
                    else if (stb_cnt != STB_MAX) stb_cnt <= stb_cnt + 1'b1;
                    if (!lock_done && lock_expire) resp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky interrupt latch; a new interrupt beats a simultaneous clear.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)            irq_pending <= 1'b0;
        else if (DRI_INTERRUPT) irq_pending <= 1'b1;
        else if (irq_clear)     irq_pending <= 1'b0;
    end

endmodule

// File: tb/tb_pll_dri_master.sv
// Bench for pll_dri_master: directed scenarios plus randomized transactions,
// with expected latency/payload derived from a cycle-count model of the
// request/ack/relock rules.
module tb_pll_dri_master;

    localparam int ACK_TIMEOUT  = 255;
    localparam int LOCK_TIMEOUT = 200;
    localparam int LOCK_STABLE  = 16;
    localparam int WAIT_LIMIT   = 2000;

    logic        CLK;
    logic        RESETN;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_relock;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [10:0] DRI_CTRL;
    logic [32:0] DRI_WDATA;
    logic [32:0] DRI_RDATA;
    logic        DRI_ARST_N;
    logic        DRI_INTERRUPT;
    logic        PLL_LOCK;
    logic        irq_pending;
    logic        irq_clear;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic lock_pat [0:LOCK_TIMEOUT-1];

    pll_dri_master #(
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE)
    ) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_relock   (req_relock),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .DRI_CTRL     (DRI_CTRL),
        .DRI_WDATA    (DRI_WDATA),
        .DRI_RDATA    (DRI_RDATA),
        .DRI_ARST_N   (DRI_ARST_N),
        .DRI_INTERRUPT(DRI_INTERRUPT),
        .PLL_LOCK     (PLL_LOCK),
        .irq_pending  (irq_pending),
        .irq_clear    (irq_clear),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset pulse that leaves the bench at a negedge with the block idle.
    task automatic do_reset();
        RESETN = 1'b0;
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        @(negedge CLK);
    endtask

    // One full transaction. d = WAIT_ACK cycle index of the ack (<0: none).
    // Model: cycle 0 is the strobe cycle; WAIT_ACK starts at cycle 1.
    task automatic run_txn(input logic w, input logic rl, input logic [8:0] a,
                           input logic [31:0] wd, input int d, input logic [31:0] pdata,
                           input int hold, input logic poke);
        int          exp_c, lock_start, got_c, strobes, run;
        logic [31:0] exp_rdata, cap_rdata;
        logic        exp_err, cap_err;

        lock_start = 2 + d;
        exp_rdata  = '0;
        if (d < 0 || d >= ACK_TIMEOUT) begin
            exp_c   = 1 + ACK_TIMEOUT;
            exp_err = 1'b1;
        end else if (w && rl) begin
            exp_c   = lock_start + LOCK_TIMEOUT;
            exp_err = 1'b1;
            for (int i = LOCK_STABLE - 1; i < LOCK_TIMEOUT; i++) begin
                run = 0;
                for (int k = i - LOCK_STABLE + 1; k <= i; k++) if (lock_pat[k]) run++;
                if (run == LOCK_STABLE) begin
                    exp_c   = lock_start + i + 1;
                    exp_err = 1'b0;
                    break;
                end
            end
        end else begin
            exp_c     = 2 + d;
            exp_err   = 1'b0;
            exp_rdata = w ? 32'h0 : pdata;
        end

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready got=%b exp=1", req_ready);
        end
        req_valid  = 1'b1;
        req_write  = w;
        req_relock = rl;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge CLK);
        // Cycle 0: strobe expected; scramble request fields to prove capture.
        req_valid  = 1'b0;
        req_write  = 1'($urandom_range(0, 1));
        req_relock = 1'($urandom_range(0, 1));
        req_addr   = 9'($urandom());
        req_wdata  = $urandom();
        checks++;
        if (DRI_CTRL !== {1'b1, w, a}) begin
            errors++;
            $display("FAIL dri_ctrl got=%h exp=%h", DRI_CTRL, {1'b1, w, a});
        end
        checks++;
        if (DRI_WDATA !== {1'b0, wd}) begin
            errors++;
            $display("FAIL dri_wdata got=%h exp=%h", DRI_WDATA, {1'b0, wd});
        end
        DRI_RDATA = {1'b0, 32'($urandom())};
        PLL_LOCK  = (w && rl) ? 1'b0 : 1'($urandom_range(0, 1));

        strobes = 0;
        got_c   = -1;
        for (int c = 1; c <= WAIT_LIMIT; c++) begin
            @(negedge CLK);
            if (DRI_CTRL[10]) strobes++;
            if (resp_valid) begin
                got_c = c;
                break;
            end
            DRI_RDATA = (c == 1 + d) ? {1'b1, pdata} : {1'b0, 32'($urandom())};
            if (w && rl && c >= lock_start && c - lock_start < LOCK_TIMEOUT)
                PLL_LOCK = lock_pat[c - lock_start];
            else if (w && rl)
                PLL_LOCK = 1'b0;
            else
                PLL_LOCK = 1'($urandom_range(0, 1));
        end
        DRI_RDATA = {1'b0, 32'($urandom())};
        PLL_LOCK  = 1'b0;

        checks++;
        if (got_c != exp_c) begin
            errors++;
            $display("FAIL resp_latency got=%0d exp=%0d", got_c, exp_c);
        end
        if (got_c < 0) begin
            do_reset();
            return;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL single_strobe extra=%0d exp=0", strobes);
        end
        checks++;
        if (resp_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL resp_rdata got=%h exp=%h", resp_rdata, exp_rdata);
        end
        checks++;
        if (resp_err !== exp_err) begin
            errors++;
            $display("FAIL resp_err got=%b exp=%b", resp_err, exp_err);
        end

        // Back-pressure: response must hold and no new request may enter.
        cap_rdata = exp_rdata;
        cap_err   = exp_err;
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                req_valid = 1'b1;
                req_addr  = 9'($urandom());
            end
            @(negedge CLK);
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== cap_rdata || resp_err !== cap_err ||
                req_ready !== 1'b0 || DRI_CTRL[10] !== 1'b0) begin
                errors++;
                $display("FAIL resp_hold cyc=%0d got v=%b d=%h e=%b rdy=%b stb=%b exp v=1 d=%h e=%b rdy=0 stb=0",
                         h, resp_valid, resp_rdata, resp_err, req_ready, DRI_CTRL[10], cap_rdata, cap_err);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge CLK);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || DRI_CTRL[10] !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake got v=%b rdy=%b stb=%b exp v=0 rdy=1 stb=0",
                     resp_valid, req_ready, DRI_CTRL[10]);
        end
    endtask

    task automatic fill_lock_high();
        for (int i = 0; i < LOCK_TIMEOUT; i++) lock_pat[i] = 1'b1;
    endtask

    task automatic test_reset();
        DRI_INTERRUPT = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
            DRI_CTRL !== 11'h0 || DRI_WDATA !== 33'h0 || irq_pending !== 1'b0 || DRI_ARST_N !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got rdy=%b v=%b e=%b d=%h ctrl=%h wd=%h irq=%b arst=%b exp all 0",
                     req_ready, resp_valid, resp_err, resp_rdata, DRI_CTRL, DRI_WDATA, irq_pending, DRI_ARST_N);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if (req_ready !== 1'b0 || irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got rdy=%b irq=%b exp 0 0", req_ready, irq_pending);
        end
        RESETN        = 1'b1;
        DRI_INTERRUPT = 1'b0;
        @(negedge CLK);
        checks++;
        if (req_ready !== 1'b1 || DRI_ARST_N !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got rdy=%b arst=%b exp 1 1", req_ready, DRI_ARST_N);
        end
    endtask

    task automatic test_read_basic();
        fill_lock_high();
        run_txn(1'b0, 1'b0, 9'h005, 32'h0, 3, 32'hA5A5_0001, 0, 1'b0);
        run_txn(1'b0, 1'b0, 9'h1FF, 32'h0, 0, 32'hDEAD_BEEF, 1, 1'b0);
    endtask

    task automatic test_relock();
        for (int i = 0; i < LOCK_TIMEOUT; i++)
            lock_pat[i] = (i >= 20 && i < 25) || (i >= 28);
        run_txn(1'b1, 1'b1, 9'h010, 32'h1234_5678, 1, 32'hFFFF_FFFF, 0, 1'b0);
        // Write without relock answers straight after the ack.
        run_txn(1'b1, 1'b0, 9'h011, 32'h0BAD_F00D, 2, 32'h5555_AAAA, 0, 1'b0);
    endtask

    task automatic test_ack_timeout();
        run_txn(1'b0, 1'b0, 9'h020, 32'h0, -1, 32'h0, 0, 1'b0);
        // Late ack while idle must not create a response.
        DRI_RDATA = {1'b1, 32'h1111_2222};
        @(negedge CLK);
        @(negedge CLK);
        DRI_RDATA = {1'b0, 32'h0};
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_ack got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready);
        end
        run_txn(1'b0, 1'b0, 9'h021, 32'h0, 0, 32'h7777_0001, 0, 1'b0);
        // Ack in the last permitted cycle succeeds; one cycle later fails.
        run_txn(1'b0, 1'b0, 9'h022, 32'h0, ACK_TIMEOUT - 1, 32'hC0DE_0254, 0, 1'b0);
        run_txn(1'b0, 1'b0, 9'h023, 32'h0, ACK_TIMEOUT, 32'hC0DE_0255, 0, 1'b0);
    endtask

    task automatic test_lock_timeout();
        for (int i = 0; i < LOCK_TIMEOUT; i++) lock_pat[i] = ((i % 10) != 9);
        run_txn(1'b1, 1'b1, 9'h030, 32'hAAAA_0000, 0, 32'h0, 0, 1'b0);
        // Stable run completing in the last permitted cycle succeeds.
        for (int i = 0; i < LOCK_TIMEOUT; i++) lock_pat[i] = (i >= LOCK_TIMEOUT - LOCK_STABLE);
        run_txn(1'b1, 1'b1, 9'h031, 32'hAAAA_0001, 0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 1'b0, 9'h040, 32'h0, 2, 32'h3C3C_5A5A, 10, 1'b1);
    endtask

    task automatic test_irq();
        logic exp_irq;
        DRI_INTERRUPT = 1'b1;
        irq_clear     = 1'b1;
        @(negedge CLK);
        DRI_INTERRUPT = 1'b0;
        checks++;
        if (irq_pending !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins got=%b exp=1", irq_pending);
        end
        @(negedge CLK);
        irq_clear = 1'b0;
        checks++;
        if (irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got=%b exp=0", irq_pending);
        end
        exp_irq = 1'b0;
        for (int i = 0; i < 30; i++) begin
            DRI_INTERRUPT = ($urandom_range(0, 3) == 0);
            irq_clear     = 1'($urandom_range(0, 1));
            exp_irq       = DRI_INTERRUPT ? 1'b1 : (irq_clear ? 1'b0 : exp_irq);
            @(negedge CLK);
            checks++;
            if (irq_pending !== exp_irq) begin
                errors++;
                $display("FAIL irq_random cyc=%0d got=%b exp=%b", i, irq_pending, exp_irq);
            end
        end
        DRI_INTERRUPT = 1'b0;
        irq_clear     = 1'b0;
    endtask

    task automatic test_reset_abort();
        int seen;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_relock = 1'b1;
        req_addr   = 9'h050;
        req_wdata  = 32'h9999_0000;
        PLL_LOCK   = 1'b0;
        @(negedge CLK);
        req_valid = 1'b0;
        DRI_RDATA = {1'b0, 32'h0};
        @(negedge CLK);
        DRI_RDATA     = {1'b1, 32'h1234_0000};
        DRI_INTERRUPT = 1'b1;
        @(negedge CLK);
        DRI_RDATA     = {1'b0, 32'h0};
        DRI_INTERRUPT = 1'b0;
        repeat (5) @(negedge CLK);
        checks++;
        if (resp_valid !== 1'b0 || irq_pending !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre got v=%b irq=%b rdy=%b exp v=0 irq=1 rdy=0",
                     resp_valid, irq_pending, req_ready);
        end
        #2 RESETN = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
            DRI_CTRL !== 11'h0 || DRI_WDATA !== 33'h0 || irq_pending !== 1'b0 || DRI_ARST_N !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset got rdy=%b v=%b e=%b d=%h ctrl=%h wd=%h irq=%b arst=%b exp all 0",
                     req_ready, resp_valid, resp_err, resp_rdata, DRI_CTRL, DRI_WDATA, irq_pending, DRI_ARST_N);
        end
        DRI_RDATA = {1'b1, 32'h4444_0000};
        PLL_LOCK  = 1'b1;
        @(negedge CLK);
        DRI_RDATA = {1'b0, 32'h0};
        @(negedge CLK);
        RESETN    = 1'b1;
        DRI_RDATA = {1'b1, 32'h4444_0001};
        @(negedge CLK);
        DRI_RDATA = {1'b0, 32'h0};
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_release_ready got=%b exp=1", req_ready);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (resp_valid !== 1'b0 || DRI_CTRL[10] !== 1'b0) seen++;
        end
        PLL_LOCK = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_resp got=%0d bad cycles exp=0", seen);
        end
        fill_lock_high();
        run_txn(1'b0, 1'b0, 9'h051, 32'h0, 1, 32'h6666_0051, 0, 1'b0);
    endtask

    task automatic test_random();
        int          d, pre;
        logic        w, rl;
        for (int n = 0; n < 12; n++) begin
            w   = 1'($urandom_range(0, 1));
            rl  = 1'($urandom_range(0, 1));
            d   = $urandom_range(0, 6);
            pre = $urandom_range(0, 40);
            for (int i = 0; i < LOCK_TIMEOUT; i++)
                lock_pat[i] = (i >= pre) ? 1'b1 : ($urandom_range(0, 9) < 7);
            run_txn(w, rl, 9'($urandom()), $urandom(), d, $urandom(),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    // Test sequence and summary.
    initial begin
        RESETN        = 1'b0;
        req_valid     = 1'b0;
        req_write     = 1'b0;
        req_relock    = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        resp_ready    = 1'b0;
        DRI_RDATA     = '0;
        DRI_INTERRUPT = 1'b0;
        PLL_LOCK      = 1'b0;
        irq_clear     = 1'b0;

        test_reset();
        test_read_basic();
        test_relock();
        test_ack_timeout();
        test_lock_timeout();
        test_backpressure();
        test_irq();
        test_reset_abort();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
